// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage at the ROB head. Retires up to two
// completed entries per cycle, updates the committed register file, returns
// superseded physical tags to the free list and releases committed stores.
module retire_unit #(
  parameter int TAG_W = 6,
  parameter int ROB_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             head0_valid,
  input  logic             head0_complete,
  input  logic             head0_has_rd,
  input  logic [4:0]       head0_arch_rd,
  input  logic [TAG_W-1:0] head0_old_tag,
  input  logic [31:0]      head0_value,
  input  logic             head0_is_store,
  input  logic [ROB_W-1:0] head0_rob_index,
  input  logic             head1_valid,
  input  logic             head1_complete,
  input  logic             head1_has_rd,
  input  logic [4:0]       head1_arch_rd,
  input  logic [TAG_W-1:0] head1_old_tag,
  input  logic [31:0]      head1_value,
  input  logic             head1_is_store,
  input  logic [ROB_W-1:0] head1_rob_index,
  input  logic             fetch_complete,
  input  logic             rob_empty,
  output logic [1:0]       dequeue_count,
  output logic             freed_valid_1,
  output logic             freed_valid_2,
  output logic [TAG_W-1:0] freed_tag_1,
  output logic [TAG_W-1:0] freed_tag_2,
  output logic             store_commit_valid,
  output logic [ROB_W-1:0] store_commit_rob_index,
  output logic [31:0]      a0,
  output logic [31:0]      a1,
  output logic [31:0]      retired_total,
  output logic             done
);

  logic [31:0]      arch_reg_q [32];
  logic [31:0]      arch_reg_d [32];
  logic             freed_valid_1_q, freed_valid_1_d;
  logic             freed_valid_2_q, freed_valid_2_d;
  logic [TAG_W-1:0] freed_tag_1_q, freed_tag_1_d;
  logic [TAG_W-1:0] freed_tag_2_q, freed_tag_2_d;
  logic             store_commit_valid_q, store_commit_valid_d;
  logic [ROB_W-1:0] store_commit_rob_index_q, store_commit_rob_index_d;
  logic [31:0]      retired_total_q, retired_total_d;
  logic             done_q, done_d;

  logic retire0, retire1;
  logic write0, write1;

  // Retire decision: in-order, at most one store per cycle, nothing once done.
  always_comb begin
    retire0 = 1'b0;
    retire1 = 1'b0;
    if (!reset && !done_q) begin
      retire0 = head0_valid && head0_complete;
      retire1 = retire0 && head1_valid && head1_complete &&
                !(head0_is_store && head1_is_store);
    end
    write0        = retire0 && head0_has_rd && (head0_arch_rd != 5'd0);
    write1        = retire1 && head1_has_rd && (head1_arch_rd != 5'd0);
    dequeue_count = {1'b0, retire0} + {1'b0, retire1};
  end

  // Next-state for register file, free-list strobes, store commit, counters.
  always_comb begin
    arch_reg_d = arch_reg_q;
    // Slot 1 is younger, so its write is applied last and wins on a collision.
    if (write0) arch_reg_d[head0_arch_rd] = head0_value;
    if (write1) arch_reg_d[head1_arch_rd] = head1_value;
    arch_reg_d[0] = '0;

    freed_valid_1_d = write0;
    freed_valid_2_d = write1;
    freed_tag_1_d   = write0 ? head0_old_tag : freed_tag_1_q;
    freed_tag_2_d   = write1 ? head1_old_tag : freed_tag_2_q;

    store_commit_valid_d     = 1'b0;
    store_commit_rob_index_d = store_commit_rob_index_q;
    if (retire0 && head0_is_store) begin
      store_commit_valid_d     = 1'b1;
      store_commit_rob_index_d = head0_rob_index;
    end else if (retire1 && head1_is_store) begin
      store_commit_valid_d     = 1'b1;
      store_commit_rob_index_d = head1_rob_index;
    end

    retired_total_d = retired_total_q + 32'(dequeue_count);
    done_d          = done_q || (fetch_complete && rob_empty && (dequeue_count == 2'd0));
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_reg_q               <= '{default: '0};
      freed_valid_1_q          <= 1'b0;
      freed_valid_2_q          <= 1'b0;
      freed_tag_1_q            <= '0;
      freed_tag_2_q            <= '0;
      store_commit_valid_q     <= 1'b0;
      store_commit_rob_index_q <= '0;
      retired_total_q          <= '0;
      done_q                   <= 1'b0;
    end else begin
      arch_reg_q               <= arch_reg_d;
      freed_valid_1_q          <= freed_valid_1_d;
      freed_valid_2_q          <= freed_valid_2_d;
      freed_tag_1_q            <= freed_tag_1_d;
      freed_tag_2_q            <= freed_tag_2_d;
      store_commit_valid_q     <= store_commit_valid_d;
      store_commit_rob_index_q <= store_commit_rob_index_d;
      retired_total_q          <= retired_total_d;
      done_q                   <= done_d;
    end
  end

  assign freed_valid_1          = freed_valid_1_q;
  assign freed_valid_2          = freed_valid_2_q;
  assign freed_tag_1            = freed_tag_1_q;
  assign freed_tag_2            = freed_tag_2_q;
  assign store_commit_valid     = store_commit_valid_q;
  assign store_commit_rob_index = store_commit_rob_index_q;
  assign a0                     = arch_reg_q[10];
  assign a1                     = arch_reg_q[11];
  assign retired_total          = retired_total_q;
  assign done                   = done_q;

endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit: directed vector table for retire_unit plus hand-written
// reset sequences.
module tb_retire_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        head0_valid, head0_complete, head0_has_rd, head0_is_store;
  logic [4:0]  head0_arch_rd;
  logic [5:0]  head0_old_tag, head0_rob_index;
  logic [31:0] head0_value;
  logic        head1_valid, head1_complete, head1_has_rd, head1_is_store;
  logic [4:0]  head1_arch_rd;
  logic [5:0]  head1_old_tag, head1_rob_index;
  logic [31:0] head1_value;
  logic        fetch_complete, rob_empty;
  logic [1:0]  dequeue_count;
  logic        freed_valid_1, freed_valid_2;
  logic [5:0]  freed_tag_1, freed_tag_2;
  logic        store_commit_valid;
  logic [5:0]  store_commit_rob_index;
  logic [31:0] a0, a1, retired_total;
  logic        done;

  int checks = 0;
  int errors = 0;

  retire_unit #(.TAG_W(6), .ROB_W(6)) dut (
    .clk(clk), .reset(reset),
    .head0_valid(head0_valid), .head0_complete(head0_complete),
    .head0_has_rd(head0_has_rd), .head0_arch_rd(head0_arch_rd),
    .head0_old_tag(head0_old_tag), .head0_value(head0_value),
    .head0_is_store(head0_is_store), .head0_rob_index(head0_rob_index),
    .head1_valid(head1_valid), .head1_complete(head1_complete),
    .head1_has_rd(head1_has_rd), .head1_arch_rd(head1_arch_rd),
    .head1_old_tag(head1_old_tag), .head1_value(head1_value),
    .head1_is_store(head1_is_store), .head1_rob_index(head1_rob_index),
    .fetch_complete(fetch_complete), .rob_empty(rob_empty),
    .dequeue_count(dequeue_count),
    .freed_valid_1(freed_valid_1), .freed_valid_2(freed_valid_2),
    .freed_tag_1(freed_tag_1), .freed_tag_2(freed_tag_2),
    .store_commit_valid(store_commit_valid),
    .store_commit_rob_index(store_commit_rob_index),
    .a0(a0), .a1(a1), .retired_total(retired_total), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, c, hr;
    logic [4:0]  rd;
    logic [5:0]  ot;
    logic [31:0] val;
    logic        st;
    logic [5:0]  ri;
  } head_t;

  typedef struct {
    head_t       h0, h1;
    logic        fc, re;
    logic [1:0]  dq;
    logic        fv1;
    logic [5:0]  ft1;
    logic        fv2;
    logic [5:0]  ft2;
    logic        sv;
    logic [5:0]  si;
    logic [31:0] ea0, ea1, tot;
    logic        dn;
  } vec_t;

  function automatic head_t H(logic v, logic c, logic hr, logic [4:0] rd,
                              logic [5:0] ot, logic [31:0] val, logic st,
                              logic [5:0] ri);
    head_t h;
    h.v = v; h.c = c; h.hr = hr; h.rd = rd; h.ot = ot; h.val = val; h.st = st; h.ri = ri;
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input head_t h0, input head_t h1, input logic fc, input logic re);
    head0_valid = h0.v; head0_complete = h0.c; head0_has_rd = h0.hr;
    head0_arch_rd = h0.rd; head0_old_tag = h0.ot; head0_value = h0.val;
    head0_is_store = h0.st; head0_rob_index = h0.ri;
    head1_valid = h1.v; head1_complete = h1.c; head1_has_rd = h1.hr;
    head1_arch_rd = h1.rd; head1_old_tag = h1.ot; head1_value = h1.val;
    head1_is_store = h1.st; head1_rob_index = h1.ri;
    fetch_complete = fc; rob_empty = re;
  endtask

  vec_t  vecs [16];
  head_t NO;

  initial begin
    NO = H(0, 0, 0, 0, 0, 0, 0, 0);
    //          h0                               h1                               fc re dq fv1 ft1 fv2 ft2 sv si a0   a1   tot dn
    vecs[0]  = '{H(1,1,1,10,12,5,0,1),         NO,                              0, 0, 1, 1, 12, 0, 0,  0, 0, 5,   0,   1,  0};
    vecs[1]  = '{H(1,1,1,11,20,3,0,2),         H(1,1,1,11,21,9,0,3),            0, 0, 2, 1, 20, 1, 21, 0, 0, 5,   9,   3,  0};
    vecs[2]  = '{H(1,0,1,5,22,100,0,4),        H(1,1,1,6,23,200,0,5),           0, 0, 0, 0, 0,  0, 0,  0, 0, 5,   9,   3,  0};
    vecs[3]  = '{H(1,1,1,5,22,100,0,4),        H(1,1,1,6,23,200,0,5),           0, 0, 2, 1, 22, 1, 23, 0, 0, 5,   9,   5,  0};
    vecs[4]  = '{H(1,1,0,0,0,0,1,4),           H(1,1,0,0,0,0,1,5),              0, 0, 1, 0, 0,  0, 0,  1, 4, 5,   9,   6,  0};
    vecs[5]  = '{H(1,1,0,0,0,0,1,5),           NO,                              0, 0, 1, 0, 0,  0, 0,  1, 5, 5,   9,   7,  0};
    vecs[6]  = '{H(1,1,1,0,30,7,0,6),          NO,                              0, 0, 1, 0, 0,  0, 0,  0, 0, 5,   9,   8,  0};
    vecs[7]  = '{H(1,1,1,10,31,42,0,7),        H(1,1,0,0,0,0,1,8),              0, 0, 2, 1, 31, 0, 0,  1, 8, 42,  9,   10, 0};
    vecs[8]  = '{H(1,1,1,11,1,111,0,9),        H(1,1,1,11,2,222,0,10),          0, 0, 2, 1, 1,  1, 2,  0, 0, 42,  222, 12, 0};
    vecs[9]  = '{H(1,1,1,10,33,7,0,11),        H(1,1,1,11,33,8,0,12),           0, 0, 2, 1, 33, 1, 33, 0, 0, 7,   8,   14, 0};
    vecs[10] = '{NO,                           H(1,1,1,10,3,999,0,0),           0, 0, 0, 0, 0,  0, 0,  0, 0, 7,   8,   14, 0};
    vecs[11] = '{H(1,1,0,0,0,0,1,12),          H(1,1,1,10,40,55,0,13),          0, 0, 2, 0, 0,  1, 40, 1, 12, 55, 8,   16, 0};
    vecs[12] = '{NO,                           NO,                              1, 0, 0, 0, 0,  0, 0,  0, 0, 55,  8,   16, 0};
    vecs[13] = '{H(1,1,1,10,41,66,0,14),       NO,                              1, 1, 1, 1, 41, 0, 0,  0, 0, 66,  8,   17, 0};
    vecs[14] = '{NO,                           NO,                              1, 1, 0, 0, 0,  0, 0,  0, 0, 66,  8,   17, 1};
    vecs[15] = '{H(1,1,1,11,42,77,0,15),       NO,                              0, 0, 0, 0, 0,  0, 0,  0, 0, 66,  8,   17, 1};

    // Reset state, with a completed head present to show dequeue_count is held at 0.
    reset = 1'b1;
    drive(H(1,1,1,10,12,5,0,1), NO, 0, 0);
    #2;
    chk("rst_dq", 32'(dequeue_count), 0);
    chk("rst_fv1", 32'(freed_valid_1), 0);
    chk("rst_fv2", 32'(freed_valid_2), 0);
    chk("rst_ft1", 32'(freed_tag_1), 0);
    chk("rst_ft2", 32'(freed_tag_2), 0);
    chk("rst_sv", 32'(store_commit_valid), 0);
    chk("rst_si", 32'(store_commit_rob_index), 0);
    chk("rst_a0", a0, 0);
    chk("rst_a1", a1, 0);
    chk("rst_tot", retired_total, 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(NO, NO, 0, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].h0, vecs[i].h1, vecs[i].fc, vecs[i].re);
      #1;
      chk($sformatf("v%0d_dq", i), 32'(dequeue_count), 32'(vecs[i].dq));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fv1", i), 32'(freed_valid_1), 32'(vecs[i].fv1));
      chk($sformatf("v%0d_fv2", i), 32'(freed_valid_2), 32'(vecs[i].fv2));
      if (vecs[i].fv1) chk($sformatf("v%0d_ft1", i), 32'(freed_tag_1), 32'(vecs[i].ft1));
      if (vecs[i].fv2) chk($sformatf("v%0d_ft2", i), 32'(freed_tag_2), 32'(vecs[i].ft2));
      chk($sformatf("v%0d_sv", i), 32'(store_commit_valid), 32'(vecs[i].sv));
      if (vecs[i].sv) chk($sformatf("v%0d_si", i), 32'(store_commit_rob_index), 32'(vecs[i].si));
      chk($sformatf("v%0d_a0", i), a0, vecs[i].ea0);
      chk($sformatf("v%0d_a1", i), a1, vecs[i].ea1);
      chk($sformatf("v%0d_tot", i), retired_total, vecs[i].tot);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      if (i == 6) chk("x0_zero", dut.arch_reg_q[0], 0);
    end

    // Asynchronous reset mid-cycle while a0 is non-zero and done is set.
    @(negedge clk);
    drive(NO, NO, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_a0", a0, 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_tot", retired_total, 0);
    @(negedge clk);
    reset = 1'b0;

    // Rebuild a0 = 5 after reset.
    drive(H(1,1,1,10,12,5,0,1), NO, 0, 0);
    #1;
    chk("re_dq", 32'(dequeue_count), 1);
    @(posedge clk);
    #1;
    chk("re_a0", a0, 5);
    chk("re_ft1", 32'(freed_tag_1), 12);
    chk("re_tot", retired_total, 1);

    // Reset asserted while a retirement is being offered: it must be discarded.
    @(negedge clk);
    drive(H(1,1,1,11,9,77,1,3), NO, 0, 0);
    #1;
    chk("fl_dq", 32'(dequeue_count), 1);
    reset = 1'b1;
    #1;
    chk("fl_dq_rst", 32'(dequeue_count), 0);
    chk("fl_a0", a0, 0);
    @(posedge clk);
    #1;
    chk("fl_a1", a1, 0);
    chk("fl_sv", 32'(store_commit_valid), 0);
    chk("fl_fv1", 32'(freed_valid_1), 0);
    chk("fl_tot", retired_total, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(NO, NO, 0, 0);
    @(posedge clk);
    #1;
    chk("idle_tot", retired_total, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
